// File: rtl/vegeta_array_ctrl_fp6.sv
`default_nettype none
// ============================================================================
// Module   : vegeta_array_ctrl_fp6
// Brief    : Column-stack sequencer: weight preload, activation stream, drain.
// Revision : 1.0
// ============================================================================
module vegeta_array_ctrl_fp6 #(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_gemm_mode,
   input  logic [CNT_W-1:0] cmd_num_act,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic             act_valid,
   output logic             act_ready,
   output logic             act_zero,
   output logic [1:0]       pe_mode,
   output logic [1:0]       pe_gemm_mode,
   output logic             pe_weight_transferring,
   output logic             pe_i_wb,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int C_DRAIN_LEN = NUM_ROWS + NUM_COLS - 1;
   localparam int C_ROW_W     = $clog2(NUM_ROWS + 1);
   localparam int C_DRN_W     = $clog2(C_DRAIN_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WLOAD   = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t             r_state;
   logic [1:0]         r_gemm_mode;
   logic [CNT_W-1:0]   r_num_act;
   logic [C_ROW_W-1:0] r_row_cnt;
   logic [CNT_W-1:0]   r_act_cnt;
   logic [C_DRN_W-1:0] r_drn_cnt;
   logic               r_err_pend;
   logic               r_i_wb;

   // Each counter advances only below its terminal value and the terminal beat
   // leaves the state, so no counter can wrap inside a tile.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gemm_mode <= 2'b00;
         r_num_act   <= '0;
         r_row_cnt   <= '0;
         r_act_cnt   <= '0;
         r_drn_cnt   <= '0;
         r_err_pend  <= 1'b0;
         r_i_wb      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_gemm_mode <= cmd_gemm_mode;
                  r_num_act   <= cmd_num_act;
                  r_row_cnt   <= '0;
                  r_act_cnt   <= '0;
                  r_drn_cnt   <= '0;
                  if (cmd_gemm_mode == 2'b11) begin
                     r_err_pend <= 1'b1;
                     r_state    <= S_FIN;
                  end else begin
                     r_err_pend <= 1'b0;
                     r_state    <= S_WLOAD;
                  end
               end
            end
            S_WLOAD: begin
               if (w_valid) begin
                  if (r_row_cnt == C_ROW_W'(NUM_ROWS - 1)) begin
                     r_i_wb  <= ~r_i_wb;
                     r_state <= (r_num_act == '0) ? S_FIN : S_COMPUTE;
                  end else begin
                     r_row_cnt <= r_row_cnt + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               if (act_valid) begin
                  if (r_act_cnt == r_num_act - 1'b1) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_act_cnt <= r_act_cnt + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drn_cnt == C_DRN_W'(C_DRAIN_LEN - 1)) begin
                  r_state <= S_FIN;
               end else begin
                  r_drn_cnt <= r_drn_cnt + 1'b1;
               end
            end
            S_FIN: begin
               r_err_pend <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready              = (r_state == S_IDLE);
   assign w_ready                = (r_state == S_WLOAD);
   assign act_ready              = (r_state == S_COMPUTE);
   assign act_zero               = (r_state == S_DRAIN);
   assign busy                   = (r_state != S_IDLE);
   assign done                   = (r_state == S_FIN);
   assign err                    = (r_state == S_FIN) && r_err_pend;
   assign pe_gemm_mode           = r_gemm_mode;
   assign pe_i_wb                = r_i_wb;
   assign pe_weight_transferring = (r_state == S_WLOAD) && w_valid;

   // A stalled feeder parks the PEs in hold so nothing shifts.
   always_comb begin
      pe_mode = 2'b00;
      if ((r_state == S_WLOAD) && w_valid) begin
         pe_mode = 2'b01;
      end else if (((r_state == S_COMPUTE) && act_valid) || (r_state == S_DRAIN)) begin
         pe_mode = 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: doc/vegeta_array_ctrl_fp6.md
Name: vegeta_array_ctrl_fp6

Overview:
- Sequencer for one column-stack of vegeta_pe_fp6 tiles.
- Accepts a GEMM tile command and drives the shared PE control bus (mode, gemm_mode, weight_transferring, i_wb) through three phases: weight preload, activation streaming, and pipeline drain.
- Arbitrates the weight and activation feeders with valid/ready handshakes and reports completion to the tile scheduler.

Parameters:
- NUM_ROWS, 4, PE rows weights shift through; weight-load beats per command.
- NUM_COLS, 4, PE columns; drain length is NUM_ROWS+NUM_COLS-1.
- CNT_W, 16, width of activation-count fields and counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  tile command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_gemm_mode  in  2  00 dense, 01 2:4, 10 1:4, 11 reserved.
- cmd_num_act  in  CNT_W  activation vectors to stream.
- w_valid  in  1  weight feeder has a row beat.
- w_ready  out  1  weight beat consumed this cycle.
- act_valid  in  1  activation feeder has a vector.
- act_ready  out  1  activation vector consumed this cycle.
- act_zero  out  1  feeder must drive zero activations (drain).
- pe_mode  out  2  00 hold, 01 weight load, 10 compute/shift.
- pe_gemm_mode  out  2  latched gemm mode to PEs.
- pe_weight_transferring  out  1  weight shift enable.
- pe_i_wb  out  1  buffer receiving the next weight load.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the tile finishes.
- err  out  1  one-cycle pulse with done for a reserved gemm mode.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0 except cmd_ready=1. Counters 0. pe_i_wb=0. Reset applies in any state and aborts the in-flight tile with no done pulse.
- States: IDLE, WLOAD, COMPUTE, DRAIN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch gemm_mode and num_act into internal registers.
  - If gemm_mode==11, go to FIN with err pending.
  - Otherwise go to WLOAD with the row counter cleared.
- WLOAD:
  - w_ready=1.
  - Each cycle with w_valid=1: pe_mode=01, pe_weight_transferring=1, row counter increments.
  - Cycles with w_valid=0: pe_mode=00, pe_weight_transferring=0 (stall).
  - When the beat with row counter==NUM_ROWS-1 is accepted, toggle pe_i_wb on the next edge.
  - Then go to COMPUTE, or to FIN if latched num_act==0.
- COMPUTE:
  - act_ready=1.
  - Each cycle with act_valid=1: pe_mode=10, act counter increments.
  - Cycles with act_valid=0: pe_mode=00, so PEs hold and act_out does not shift.
  - When the beat with counter==num_act-1 is accepted, go to DRAIN.
- DRAIN:
  - pe_mode=10 and act_zero=1 for exactly NUM_ROWS+NUM_COLS-1 cycles.
  - act_ready=0. The drain is not stallable.
  - Then go to FIN.
- FIN:
  - done=1 for one cycle; err=1 that same cycle if the gemm mode was reserved.
  - Then go to IDLE.
- pe_gemm_mode holds its latched value from command accept until the next accept. It is 0 after reset.
- Handshake outputs are combinational from state only and never depend on valid inputs (no loops).
- cmd_ready=0 in all states except IDLE. A command presented while busy is held off.
- Counters saturate at their terminal values and never wrap mid-tile. num_act=2^CNT_W-1 must complete correctly.
- pe_weight_transferring=1 only in WLOAD on an accepted beat.

Test Plan:
- Reset then dense cmd, NUM_ROWS=4, num_act=3, valids held high -> 4 cycles pe_mode=01, pe_i_wb 0->1, 3 cycles pe_mode=10, 7 drain cycles with act_zero=1, done pulse at cycle 15 after accept.
- Weight-beat stall: w_valid toggles 1,0,1,0 -> pe_mode alternates 01/00 and weight_transferring tracks it; exactly 4 accepted beats before COMPUTE.
- Activation stall: act_valid low for 2 cycles mid-stream -> pe_mode=00 during the gap; act_ready beats total equals num_act=5; drain unchanged.
- cmd_num_act=0 -> WLOAD, then FIN directly with no pe_mode=10 cycles; done=1; pe_i_wb toggled.
- cmd_gemm_mode=11 -> no WLOAD; done=1 and err=1 in the same cycle; pe_i_wb unchanged.
- rst_n=0 for one cycle during COMPUTE -> next cycle IDLE, pe_mode=00, pe_i_wb=0, no done; a new command is accepted immediately afterward.
